// File: rtl/alu_result_serializer.sv
// +----------------------------------------------------------------------------+
// | Module   : alu_result_serializer                                           |
// | Purpose  : Frames one ALU result plus flags as HEADER, result bytes (MS    |
// |            first), flags, XOR checksum over a valid/ready byte stream.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module alu_result_serializer #(
  parameter int          N      = 16,
  parameter logic [7:0]  HEADER = 8'hA5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         res_valid,
  output logic         res_ready,
  input  logic [N-1:0] result,
  input  logic [4:0]   flags,
  output logic [7:0]   tx_data,
  output logic         tx_valid,
  input  logic         tx_ready,
  output logic         busy,
  output logic         frame_done
);

  localparam int         c_NB      = N / 8;
  localparam logic [1:0] c_CNT_TOP = 2'(c_NB - 1);

  localparam logic [2:0] c_IDLE = 3'd0;
  localparam logic [2:0] c_HDR  = 3'd1;
  localparam logic [2:0] c_DATA = 3'd2;
  localparam logic [2:0] c_FLG  = 3'd3;
  localparam logic [2:0] c_CHK  = 3'd4;

  logic [2:0]   r_state;
  logic [N-1:0] r_shift;
  logic [4:0]   r_flags;
  logic [1:0]   r_cnt;
  logic [7:0]   r_chk;
  logic [7:0]   r_tx_data;
  logic         r_tx_valid;
  logic         r_frame_done;

  logic         w_idle;
  logic         w_res_hs;
  logic         w_tx_hs;

  assign w_idle   = (r_state == c_IDLE);
  assign w_res_hs = res_valid & w_idle;
  assign w_tx_hs  = r_tx_valid & tx_ready;

  assign res_ready  = w_idle;
  assign busy       = ~w_idle;
  assign tx_data    = r_tx_data;
  assign tx_valid   = r_tx_valid;
  assign frame_done = r_frame_done;

  // Result bytes leave from the top of a shift register, so the MS byte is
  // always r_shift[N-1 -: 8] and no variable indexing is needed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= c_IDLE;
      r_shift      <= '0;
      r_flags      <= '0;
      r_cnt        <= '0;
      r_chk        <= '0;
      r_tx_data    <= '0;
      r_tx_valid   <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        c_IDLE: begin
          if (w_res_hs) begin
            r_shift    <= result;
            r_flags    <= flags;
            r_tx_data  <= HEADER;
            r_tx_valid <= 1'b1;
            r_chk      <= HEADER;
            r_state    <= c_HDR;
          end
        end
        c_HDR: begin
          if (w_tx_hs) begin
            r_tx_data <= r_shift[N-1 -: 8];
            r_shift   <= r_shift << 8;
            r_cnt     <= c_CNT_TOP;
            r_state   <= c_DATA;
          end
        end
        c_DATA: begin
          if (w_tx_hs) begin
            r_chk <= r_chk ^ r_tx_data;
            if (r_cnt != 2'd0) begin
              r_tx_data <= r_shift[N-1 -: 8];
              r_shift   <= r_shift << 8;
              r_cnt     <= r_cnt - 2'd1;
            end else begin
              r_tx_data <= {3'b000, r_flags};
              r_state   <= c_FLG;
            end
          end
        end
        c_FLG: begin
          // Fold the flags byte in and present the finished checksum at once.
          if (w_tx_hs) begin
            r_chk     <= r_chk ^ r_tx_data;
            r_tx_data <= r_chk ^ r_tx_data;
            r_state   <= c_CHK;
          end
        end
        c_CHK: begin
          if (w_tx_hs) begin
            r_tx_valid   <= 1'b0;
            r_frame_done <= 1'b1;
            r_state      <= c_IDLE;
          end
        end
        default: begin
          r_tx_valid <= 1'b0;
          r_state    <= c_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire
